regfile_write_arbiter: RTL and testbench

Shares the single write port of the 16 x 32-bit register file between three writeback sources: ALU, load unit and special/CSR unit. Round-robin arbitration admits one write per cycle, and the write is registered onto the register file's WriteReg/Data/WriteEnable inputs. A 16-entry pending-write scoreboard tracks registers claimed at issue, so the issue stage can stall on read-after-write hazards. Register 0 is hard-wired zero and is never written or marked busy.

---
 rtl/regfile_write_arbiter.sv | 169 ++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 16 x 32-bit register file.
// Three writeback sources (ALU, load, special) share one registered write port
// under round-robin arbitration. A pending-write scoreboard tracks registers
// claimed at issue so the issue stage can detect read-after-write hazards.
module regfile_write_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  Reset,
   input  logic [2:0]            ReqValid,
   input  logic [3*ADDR_W-1:0]   ReqReg,
   input  logic [3*DATA_W-1:0]   ReqData,
   output logic [2:0]            ReqReady,
   input  logic                  Claim,
   input  logic [ADDR_W-1:0]     ClaimReg,
   output logic                  ClaimOk,
   input  logic [ADDR_W-1:0]     Read1,
   input  logic [ADDR_W-1:0]     Read2,
   input  logic [ADDR_W-1:0]     Read3,
   output logic                  Busy1,
   output logic                  Busy2,
   output logic                  Busy3,
   output logic [ADDR_W-1:0]     WriteReg,
   output logic [DATA_W-1:0]     Data,
   output logic                  WriteEnable
);

   localparam int unsigned NumSrc  = 3;
   localparam int unsigned NumRegs = 1 << ADDR_W;

   // Round-robin pointer, always in 0..2
   logic [1:0]             ptr_q, ptr_d;

   // Arbitration result
   logic [NumSrc-1:0]      grant;
   logic [1:0]             gsel;
   logic                   xfer;
   logic [2:0]             rr_idx;

   // Unpacked per-source request fields
   logic [ADDR_W-1:0]      src_reg  [NumSrc];
   logic [DATA_W-1:0]      src_data [NumSrc];
   logic [ADDR_W-1:0]      sel_reg;
   logic [DATA_W-1:0]      sel_data;

   // Pending-write scoreboard; bit 0 never set
   logic [NumRegs-1:0]     pend_q, pend_d;
   logic                   claim_ok;

   // Write stage towards the register file
   logic [ADDR_W-1:0]      wr_reg_q;
   logic [DATA_W-1:0]      wr_data_q;
   logic                   wr_en_q;

   // Hazard for one read port: claimed-but-unwritten, or write still in flight
   function automatic logic hazard(input logic [ADDR_W-1:0]  rd,
                                   input logic [NumRegs-1:0] pend,
                                   input logic               we,
                                   input logic [ADDR_W-1:0]  wreg);
      return (rd != '0) && (pend[rd] || (we && (wreg == rd)));
   endfunction

   // Split the packed request buses into per-source fields
   always_comb begin
      for (int i = 0; i < NumSrc; i++) begin
         src_reg[i]  = ReqReg[i*ADDR_W +: ADDR_W];
         src_data[i] = ReqData[i*DATA_W +: DATA_W];
      end
   end

   // Round-robin search starting at ptr_q; first valid source wins
   always_comb begin
      grant  = '0;
      gsel   = 2'd0;
      rr_idx = 3'd0;
      for (int k = 0; k < NumSrc; k++) begin
         rr_idx = {1'b0, ptr_q} + 3'(k);
         if (rr_idx >= 3'd3) begin
            rr_idx = rr_idx - 3'd3;
         end
         if ((grant == '0) && ReqValid[rr_idx[1:0]]) begin
            grant[rr_idx[1:0]] = 1'b1;
            gsel               = rr_idx[1:0];
         end
      end
   end

   assign xfer     = |grant;
   assign ReqReady = grant;

   // Mux the granted source onto the write path
   always_comb begin
      sel_reg  = src_reg[0];
      sel_data = src_data[0];
      case (gsel)
         2'd1: begin
            sel_reg  = src_reg[1];
            sel_data = src_data[1];
         end
         2'd2: begin
            sel_reg  = src_reg[2];
            sel_data = src_data[2];
         end
         default: begin
            sel_reg  = src_reg[0];
            sel_data = src_data[0];
         end
      endcase
   end

   // Pointer moves past the granted source; holds when idle
   always_comb begin
      ptr_d = ptr_q;
      if (xfer) begin
         ptr_d = (gsel == 2'd2) ? 2'd0 : gsel + 2'd1;
      end
   end

   assign claim_ok = (ClaimReg == '0) || !pend_q[ClaimReg];
   assign ClaimOk  = claim_ok;

   // Scoreboard update: commit clears, then a same-register claim overrides
   always_comb begin
      pend_d = pend_q;
      if (xfer) begin
         pend_d[sel_reg] = 1'b0;
      end
      if (Claim && claim_ok && (ClaimReg != '0)) begin
         pend_d[ClaimReg] = 1'b1;
      end
      pend_d[0] = 1'b0;
   end

   // Arbiter pointer and scoreboard state
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         ptr_q  <= 2'd0;
         pend_q <= '0;
      end else begin
         ptr_q  <= ptr_d;
         pend_q <= pend_d;
      end
   end

   // Registered write port; writes to register 0 are accepted but dropped
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         wr_en_q   <= 1'b0;
         wr_reg_q  <= '0;
         wr_data_q <= '0;
      end else if (xfer) begin
         wr_en_q   <= (sel_reg != '0);
         wr_reg_q  <= sel_reg;
         wr_data_q <= sel_data;
      end else begin
         wr_en_q   <= 1'b0;
      end
   end

   assign WriteEnable = wr_en_q;
   assign WriteReg    = wr_reg_q;
   assign Data        = wr_data_q;

   assign Busy1 = hazard(Read1, pend_q, wr_en_q, wr_reg_q);
   assign Busy2 = hazard(Read2, pend_q, wr_en_q, wr_reg_q);
   assign Busy3 = hazard(Read3, pend_q, wr_en_q, wr_reg_q);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios followed by
// constrained-random traffic, all checked against a behavioural model.
module tb_regfile_write_arbiter;

   localparam int DW = 32;
   localparam int AW = 4;

   logic            clk = 1'b0;
   logic            Reset;
   logic [2:0]      ReqValid;
   logic [3*AW-1:0] ReqReg;
   logic [3*DW-1:0] ReqData;
   logic [2:0]      ReqReady;
   logic            Claim;
   logic [AW-1:0]   ClaimReg;
   logic            ClaimOk;
   logic [AW-1:0]   Read1, Read2, Read3;
   logic            Busy1, Busy2, Busy3;
   logic [AW-1:0]   WriteReg;
   logic [DW-1:0]   Data;
   logic            WriteEnable;

   always #5 clk = ~clk;

   regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk         (clk),
      .Reset       (Reset),
      .ReqValid    (ReqValid),
      .ReqReg      (ReqReg),
      .ReqData     (ReqData),
      .ReqReady    (ReqReady),
      .Claim       (Claim),
      .ClaimReg    (ClaimReg),
      .ClaimOk     (ClaimOk),
      .Read1       (Read1),
      .Read2       (Read2),
      .Read3       (Read3),
      .Busy1       (Busy1),
      .Busy2       (Busy2),
      .Busy3       (Busy3),
      .WriteReg    (WriteReg),
      .Data        (Data),
      .WriteEnable (WriteEnable)
   );

   int tests = 0;
   int fails = 0;

   // Behavioural model state
   int          m_ptr;
   bit          m_pend [16];
   bit          m_we;
   logic [3:0]  m_wreg;
   logic [31:0] m_wdata;
   int          m_last_g;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr   = 0;
      m_we    = 0;
      m_wreg  = '0;
      m_wdata = '0;
      for (int i = 0; i < 16; i++) m_pend[i] = 0;
   endtask

   function automatic int model_grant();
      for (int k = 0; k < 3; k++) begin
         int s;
         s = (m_ptr + k) % 3;
         if (ReqValid[s]) return s;
      end
      return -1;
   endfunction

   function automatic bit model_busy(input logic [3:0] r);
      return (r != 0) && (m_pend[r] || (m_we && (m_wreg == r)));
   endfunction

   function automatic bit model_claim_ok();
      return (ClaimReg == 0) || !m_pend[ClaimReg];
   endfunction

   task automatic idle();
      ReqValid = '0;
      Claim    = 1'b0;
      ClaimReg = '0;
      Read1    = '0;
      Read2    = '0;
      Read3    = '0;
   endtask

   task automatic set_req(input int s, input logic [3:0] r, input logic [31:0] d);
      ReqValid[s]          = 1'b1;
      ReqReg[s*AW +: AW]   = r;
      ReqData[s*DW +: DW]  = d;
   endtask

   // One clock: check combinational outputs, advance model, check write port
   task automatic cycle();
      int         g;
      bit         ok;
      logic [3:0] r;
      #2;
      g  = model_grant();
      ok = model_claim_ok();
      chk("ready", ReqReady, (g < 0) ? 3'b000 : 3'(1 << g));
      chk("claim_ok", ClaimOk, ok);
      chk("busy1", Busy1, model_busy(Read1));
      chk("busy2", Busy2, model_busy(Read2));
      chk("busy3", Busy3, model_busy(Read3));
      m_last_g = g;
      if (g >= 0) begin
         r       = ReqReg[g*AW +: AW];
         m_we    = (r != 0);
         m_wreg  = r;
         m_wdata = ReqData[g*DW +: DW];
         if (r != 0) m_pend[r] = 0;
         m_ptr   = (g + 1) % 3;
      end else begin
         m_we = 0;
      end
      if (Claim && ok && (ClaimReg != 0)) m_pend[ClaimReg] = 1;
      @(posedge clk);
      #1;
      chk("write_enable", WriteEnable, m_we);
      chk("write_reg", WriteReg, m_wreg);
      chk("write_data", Data, m_wdata);
   endtask

   // Synchronous-to-bench reset pulse ending at posedge+1
   task automatic do_reset();
      Reset = 1'b0;
      model_reset();
      #1;
      chk("rst_we", WriteEnable, 1'b0);
      chk("rst_wreg", WriteReg, 4'h0);
      chk("rst_data", Data, 32'h0);
      @(posedge clk);
      #1;
      Reset = 1'b1;
   endtask

   logic [2:0] exp_seq [6];
   bit         hv [3];
   logic [3:0] hr [3];
   logic [31:0] hd [3];

   initial begin
      Reset   = 1'b0;
      ReqReg  = '0;
      ReqData = '0;
      idle();
      model_reset();
      #2;
      Read1 = 4'd5;
      Read2 = 4'd7;
      ClaimReg = 4'd3;
      #1;
      chk("rst0_we", WriteEnable, 1'b0);
      chk("rst0_wreg", WriteReg, 4'h0);
      chk("rst0_data", Data, 32'h0);
      chk("rst0_claim_ok", ClaimOk, 1'b1);
      chk("rst0_busy1", Busy1, 1'b0);
      chk("rst0_busy2", Busy2, 1'b0);
      @(posedge clk);
      #1;
      Reset = 1'b1;
      idle();

      // ALU writes R5 = DEADBEEF
      set_req(0, 4'd5, 32'hDEADBEEF);
      Read1 = 4'd5;
      #1;
      chk("t1_ready", ReqReady, 3'b001);
      cycle();
      chk("t1_we", WriteEnable, 1'b1);
      chk("t1_wreg", WriteReg, 4'd5);
      chk("t1_data", Data, 32'hDEADBEEF);
      ReqValid = '0;
      cycle();
      chk("t1_we_once", WriteEnable, 1'b0);
      // Pointer now at 1: full contention must grant the load unit
      set_req(0, 4'd1, 32'h11);
      set_req(1, 4'd2, 32'h22);
      set_req(2, 4'd4, 32'h44);
      #1;
      chk("t1_ptr1", ReqReady, 3'b010);
      cycle();
      idle();
      cycle();

      // Full contention from Ptr=0 for 6 cycles
      do_reset();
      exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      for (int c = 0; c < 6; c++) begin
         set_req(0, 4'd1, 32'hA000_0000 + 32'(c));
         set_req(1, 4'd2, 32'hB000_0000 + 32'(c));
         set_req(2, 4'd3, 32'hC000_0000 + 32'(c));
         #1;
         chk("t2_rr", ReqReady, exp_seq[c]);
         cycle();
      end
      idle();
      cycle();

      // Claim R7; hazard and duplicate claim
      Claim = 1'b1;
      ClaimReg = 4'd7;
      cycle();
      Read1 = 4'd7;
      #1;
      chk("t3_busy", Busy1, 1'b1);
      chk("t3_claim_dup", ClaimOk, 1'b0);
      cycle();
      Claim = 1'b0;
      set_req(1, 4'd7, 32'h7777_0007);
      cycle();
      ReqValid = '0;
      #1;
      chk("t3_busy_inflight", Busy1, 1'b1);
      cycle();
      #1;
      chk("t3_busy_clear", Busy1, 1'b0);

      // Claim and commit to R3 in the same cycle: claim wins
      idle();
      Claim = 1'b1;
      ClaimReg = 4'd3;
      Read2 = 4'd3;
      set_req(0, 4'd3, 32'h3333_3333);
      cycle();
      idle();
      Read2 = 4'd3;
      #1;
      chk("t4_busy_we", Busy2, 1'b1);
      cycle();
      #1;
      chk("t4_busy_pend", Busy2, 1'b1);
      ClaimReg = 4'd3;
      #1;
      chk("t4_claim_blocked", ClaimOk, 1'b0);

      // Write to R0 is granted and dropped; R0 never busy
      idle();
      set_req(2, 4'd0, 32'hFFFFFFFF);
      cycle();
      chk("t5_we", WriteEnable, 1'b0);
      idle();
      Claim = 1'b1;
      ClaimReg = 4'd0;
      Read3 = 4'd0;
      #1;
      chk("t5_claim_ok", ClaimOk, 1'b1);
      chk("t5_busy", Busy3, 1'b0);
      cycle();

      // Reset right after a transfer
      idle();
      set_req(1, 4'd9, 32'h9999_9999);
      cycle();
      idle();
      Read1 = 4'd9;
      Read2 = 4'd3;
      #1;
      chk("t6_pre_busy1", Busy1, 1'b1);
      Reset = 1'b0;
      model_reset();
      #1;
      chk("t6_we", WriteEnable, 1'b0);
      chk("t6_busy1", Busy1, 1'b0);
      chk("t6_busy2", Busy2, 1'b0);
      chk("t6_busy3", Busy3, 1'b0);
      @(posedge clk);
      #1;
      Reset = 1'b1;
      ReqValid = 3'b111;
      #1;
      chk("t6_restart", ReqReady, 3'b001);
      cycle();

      // Random traffic; ungranted requests hold their fields
      idle();
      for (int s = 0; s < 3; s++) hv[s] = 0;
      for (int n = 0; n < 400; n++) begin
         for (int s = 0; s < 3; s++) begin
            if (!(hv[s] && (m_last_g != s))) begin
               hv[s] = ($urandom_range(9, 0) < 6);
               hr[s] = 4'($urandom_range(15, 0));
               hd[s] = $urandom;
            end
            ReqValid[s]         = hv[s];
            ReqReg[s*AW +: AW]  = hr[s];
            ReqData[s*DW +: DW] = hd[s];
         end
         Claim    = ($urandom_range(9, 0) < 4);
         ClaimReg = 4'($urandom_range(15, 0));
         Read1    = 4'($urandom_range(15, 0));
         Read2    = 4'($urandom_range(15, 0));
         Read3    = 4'($urandom_range(15, 0));
         cycle();
         for (int s = 0; s < 3; s++) if (m_last_g == s) hv[s] = 0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
